// File: rtl/tinyalu_responder.sv
// tinyalu_responder
//   Responder side of the TinyALU start/done command protocol. A command is
//   captured from A/B/op on the first posedge that sees start high with a
//   non-zero opcode. It then executes and reports completion with a
//   one-cycle done pulse. Add, and, xor and illegal opcodes finish one edge
//   after capture. Multiply finishes MUL_LATENCY edges after capture.
//
// Parameters
//   MUL_LATENCY  posedges from the capture edge to the done edge for
//                multiply, 1..15
//
// Ports
//   clk      in   clock, all state changes on posedge
//   reset_n  in   asynchronous active-low reset
//   A, B     in   8-bit unsigned operands
//   op       in   3-bit opcode (0 no_op, 1 add, 2 and, 3 xor, 4 mul,
//                 5..7 illegal)
//   start    in   command valid, held high by the initiator until done
//   done     out  one-cycle completion pulse (registered)
//   result   out  16-bit result of the last completed command, held
//   err      out  high only in the done cycle of an illegal opcode
//   busy     out  high while a command is executing or waiting for start low

module tinyalu_responder #(
  parameter int MUL_LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic [2:0]  op,
  input  logic        start,
  output logic        done,
  output logic [15:0] result,
  output logic        err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    WAIT_LOW
  } state_t;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  // The countdown holds the number of edges still to wait before done.
  // A multiply therefore loads MUL_LATENCY-1. Every other opcode loads 0.
  localparam logic [3:0] MUL_LOAD = 4'(MUL_LATENCY - 1);

  state_t      state;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [2:0]  op_q;
  logic [3:0]  count;
  logic [15:0] alu_out;
  logic        illegal;

  // The result is computed from the captured operands only. Changes on the
  // A/B/op inputs after the capture edge therefore cannot affect it. The
  // multiply is one combinational 8x8 product. Only the done timing is
  // stretched by the countdown.
  always_comb begin
    alu_out = 16'h0000;
    case (op_q)
      OP_ADD:  alu_out = {7'b0, ({1'b0, a_q} + {1'b0, b_q})};
      OP_AND:  alu_out = {8'h00, a_q & b_q};
      OP_XOR:  alu_out = {8'h00, a_q ^ b_q};
      OP_MUL:  alu_out = {8'h00, a_q} * {8'h00, b_q};
      default: alu_out = 16'h0000;
    endcase
  end

  assign illegal = (op_q > OP_MUL);

  // Command FSM with registered outputs.
  // In BUSY, the completion check comes before the abort check. A done edge
  // that coincides with start falling still completes, then leaves
  // WAIT_LOW on the following edge. The done and err pulses default to 0
  // every edge, so they can never last longer than one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      a_q    <= 8'h00;
      b_q    <= 8'h00;
      op_q   <= OP_NOP;
      count  <= 4'd0;
      done   <= 1'b0;
      err    <= 1'b0;
      busy   <= 1'b0;
      result <= 16'h0000;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start && (op != OP_NOP)) begin
            a_q   <= A;
            b_q   <= B;
            op_q  <= op;
            count <= (op == OP_MUL) ? MUL_LOAD : 4'd0;
            state <= BUSY;
            busy  <= 1'b1;
          end
        end
        BUSY: begin
          if (count == 4'd0) begin
            done   <= 1'b1;
            err    <= illegal;
            result <= illegal ? 16'h0000 : alu_out;
            state  <= WAIT_LOW;
          end else if (!start) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            count <= count - 4'd1;
          end
        end
        WAIT_LOW: begin
          if (!start) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tinyalu_responder.sv
// tb_tinyalu_responder
//   Self-checking bench for tinyalu_responder. A protocol-level reference
//   model predicts done/err/busy/result. It tracks the captured command and
//   the absolute edge at which that command is due. A compare process
//   checks every output on every negedge. Directed commands carry
//   hand-computed literal expectations. They are followed by randomized
//   commands with random hold lengths, early aborts and operand changes
//   while start is held.

module tb_tinyalu_responder;

  localparam int MUL_LAT = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  A = 8'h00;
  logic [7:0]  B = 8'h00;
  logic [2:0]  op = 3'b000;
  logic        start = 1'b0;
  logic        done;
  logic [15:0] result;
  logic        err;
  logic        busy;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  // Free-running clock. Inputs change on negedge and the DUT samples on
  // posedge.
  always #5 clk = ~clk;

  tinyalu_responder #(.MUL_LATENCY(MUL_LAT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .A       (A),
    .B       (B),
    .op      (op),
    .start   (start),
    .done    (done),
    .result  (result),
    .err     (err),
    .busy    (busy)
  );

  // Reference arithmetic, done on plain integers.
  function automatic logic [15:0] aluRef(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    int x;
    int y;
    x = int'(a);
    y = int'(b);
    case (o)
      3'd1:    return 16'(x + y);
      3'd2:    return 16'(x & y);
      3'd3:    return 16'(x ^ y);
      3'd4:    return 16'(x * y);
      default: return 16'h0000;
    endcase
  endfunction

  function automatic int latencyOf(input logic [2:0] o);
    return (o == 3'd4) ? MUL_LAT : 1;
  endfunction

  // Model state: 0 = waiting for a command, 1 = command due at edge doneAt,
  // 2 = completed and waiting for start to drop.
  int          edgeIdx = 0;
  int          doneAt = 0;
  int          mState = 0;
  logic [7:0]  capA = 8'h00;
  logic [7:0]  capB = 8'h00;
  logic [2:0]  capOp = 3'b000;
  logic        expDone = 1'b0;
  logic        expErr = 1'b0;
  logic        expBusy = 1'b0;
  logic [15:0] expResult = 16'h0000;

  // Edge numbering shared by the model. Within one edge, every reader sees
  // the pre-edge value.
  always @(posedge clk) edgeIdx <= edgeIdx + 1;

  // Behavioural model of the protocol, evaluated at each posedge. Reset
  // applies asynchronously.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mState    <= 0;
      expDone   <= 1'b0;
      expErr    <= 1'b0;
      expBusy   <= 1'b0;
      expResult <= 16'h0000;
    end else begin
      expDone <= 1'b0;
      expErr  <= 1'b0;
      if (mState == 0) begin
        if (start && op != 3'b000) begin
          capA    <= A;
          capB    <= B;
          capOp   <= op;
          doneAt  <= edgeIdx + latencyOf(op);
          mState  <= 1;
          expBusy <= 1'b1;
        end
      end else if (mState == 1) begin
        if (edgeIdx == doneAt) begin
          expDone   <= 1'b1;
          expErr    <= (capOp > 3'd4);
          expResult <= aluRef(capOp, capA, capB);
          mState    <= 2;
        end else if (!start) begin
          mState  <= 0;
          expBusy <= 1'b0;
        end
      end else begin
        if (!start) begin
          mState  <= 0;
          expBusy <= 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("done",   {15'b0, done}, {15'b0, expDone});
      checkOutput("err",    {15'b0, err},  {15'b0, expErr});
      checkOutput("busy",   {15'b0, busy}, {15'b0, expBusy});
      checkOutput("result", result, expResult);
    end
  end

  // Issues one command and waits a bounded time for done. It reports the
  // number of negedges from raising start until done was seen, and the err
  // value in that cycle. Start is then held for hold more cycles, with op
  // optionally switched to xor, before being dropped for one edge.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o,
                               input int hold, input bit changeOp,
                               output int n, output logic errSeen);
    @(negedge clk);
    A = a;
    B = b;
    op = o;
    start = 1'b1;
    n = 0;
    errSeen = 1'b0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout actual=0 expected=1 at %0t", $time);
    end
    errSeen = err;
    for (int i = 0; i < hold; i++) begin
      if (changeOp) begin
        op = 3'b011;
        A = 8'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  // Raw randomized command: start is held for k edges whatever the DUT
  // does, operands may wander while held, then start stays low for 1-2
  // edges.
  task automatic rawCommand(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o, input int k);
    @(negedge clk);
    A = a;
    B = b;
    op = o;
    start = 1'b1;
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        A = 8'($urandom);
        B = 8'($urandom);
        op = 3'($urandom);
      end
    end
    start = 1'b0;
    repeat ($urandom_range(1, 2)) @(negedge clk);
  endtask

  int   n;
  logic e;

  initial begin
    $display("[TB] tinyalu_responder bench, MUL_LATENCY=%0d", MUL_LAT);
    repeat (2) @(negedge clk);
    checkOutput("rst_done",   {15'b0, done}, 16'h0000);
    checkOutput("rst_busy",   {15'b0, busy}, 16'h0000);
    checkOutput("rst_result", result, 16'h0000);
    reset_n = 1'b1;
    checking = 1'b1;

    // Add with carry out.
    applyStimulus(8'hFF, 8'h01, 3'b001, 0, 1'b0, n, e);
    checkOutput("add_latency", 16'(n), 16'd2);
    checkOutput("add_result", result, 16'h0100);
    checkOutput("add_err", {15'b0, e}, 16'h0000);
    checkOutput("add_done_low", {15'b0, done}, 16'h0000);

    // Full-width multiply.
    applyStimulus(8'hFF, 8'hFF, 3'b100, 0, 1'b0, n, e);
    checkOutput("mul_latency", 16'(n), 16'(MUL_LAT + 1));
    checkOutput("mul_result", result, 16'hFE01);

    // Logic ops back to back.
    applyStimulus(8'hF0, 8'h3C, 3'b010, 0, 1'b0, n, e);
    checkOutput("and_result", result, 16'h0030);
    applyStimulus(8'hA5, 8'h0F, 3'b011, 0, 1'b0, n, e);
    checkOutput("xor_result", result, 16'h00AA);

    // no_op held for one edge, then again: ignored.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      A = 8'h77;
      op = 3'b000;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput("nop_done", {15'b0, done}, 16'h0000);
      checkOutput("nop_result", result, 16'h00AA);
    end

    // Illegal opcode.
    applyStimulus(8'h12, 8'h34, 3'b101, 0, 1'b0, n, e);
    checkOutput("ill_latency", 16'(n), 16'd2);
    checkOutput("ill_err", {15'b0, e}, 16'h0001);
    checkOutput("ill_result", result, 16'h0000);

    // Start held past done, with op switched to xor meanwhile.
    applyStimulus(8'h01, 8'h02, 3'b001, 5, 1'b1, n, e);
    checkOutput("hold_result", result, 16'h0003);

    // Reset in the middle of a multiply.
    @(negedge clk);
    A = 8'h10;
    B = 8'h10;
    op = 3'b100;
    start = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rst_mid_done", {15'b0, done}, 16'h0000);
    checkOutput("rst_mid_busy", {15'b0, busy}, 16'h0000);
    checkOutput("rst_mid_result", result, 16'h0000);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(8'h02, 8'h03, 3'b001, 0, 1'b0, n, e);
    checkOutput("post_rst_latency", 16'(n), 16'd2);
    checkOutput("post_rst_result", result, 16'h0005);

    // Multiply whose done edge coincides with start falling.
    rawCommand(8'h07, 8'h09, 3'b100, MUL_LAT);
    checkOutput("coincide_result", result, 16'h003F);

    // Randomized traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 250; i++) begin
      rawCommand(8'($urandom), 8'($urandom), 3'($urandom), int'($urandom_range(1, 6)));
    end

    repeat (3) @(negedge clk);
    checking = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tinyalu_responder.md
Name: tinyalu_responder

Overview:
- Responder end of the TinyALU start/done command protocol.
- Samples the operand pair A/B and a 3-bit opcode when start is asserted, then executes the operation: single-cycle add/and/xor, multi-cycle unsigned multiply.
- Returns a 16-bit result with a one-cycle done pulse.
- Sits directly under the command/result BFM as the synthesizable ALU the bench drives and monitors.

Parameters:
- MUL_LATENCY, 3, posedge count from the command-capture edge to the done edge for multiply; legal range 1..15.

Ports:
- clk      input   1   clock; all state changes on posedge.
- reset_n  input   1   reset, asynchronous, active-low.
- A        input   8   operand A, unsigned.
- B        input   8   operand B, unsigned.
- op       input   3   opcode: 000 no_op, 001 add, 010 and, 011 xor, 100 mul, 101..111 illegal.
- start    input   1   command valid; initiator holds it high until it sees done.
- done     output  1   one-cycle completion pulse, registered.
- result   output  16  result of the last completed command; held between commands.
- err      output  1   high for exactly the done cycle of an illegal-opcode command.
- busy     output  1   high while in BUSY or WAIT_LOW.

Behaviour:
- Reset (async, reset_n=0):
  - done=0, err=0, busy=0, result=16'h0000.
  - FSM goes to IDLE; capture registers and cycle counter clear.
  - Takes effect immediately, mid-operation included; no done is ever issued for an aborted command.
- FSM states: IDLE, BUSY, WAIT_LOW.
- IDLE:
  - Posedge with start=1 and op=000: no action, stay IDLE, no done. Repeated edges with no_op are each ignored.
  - Posedge with start=1 and op!=000: capture A, B and op into internal registers, then go to BUSY. This is the capture edge N.
  - Latency L = 1 for add/and/xor/illegal, L = MUL_LATENCY for mul. The counter loads L-1.
- BUSY:
  - Counter decrements each posedge.
  - At edge N+L: done=1, result updated, err set if op was illegal, go to WAIT_LOW.
  - If start=0 at any BUSY posedge before completion: abort. Go to IDLE, no done, result and err unchanged.
  - Changes on A/B/op after the capture edge are ignored; the captured copies are used.
- WAIT_LOW:
  - done and err drop to 0 at the first posedge after the done edge. done is never high for two consecutive cycles.
  - Remain in WAIT_LOW while start=1. No re-capture, even if op/A/B change.
  - Go to IDLE on the first posedge with start=0.
  - Consequence: a new command needs start low for at least one posedge between commands.
- Arithmetic (all operands unsigned):
  - add = {7'b0, A+B (9-bit carry)}.
  - and = {8'h00, A&B}.
  - xor = {8'h00, A^B}.
  - mul = A*B, full 16-bit product.
  - illegal = 16'h0000, err=1.
- Multiply may be staged or pipelined internally. Only the done-edge timing is architectural.
- MUL_LATENCY=1 makes mul behave like a single-cycle op.
- Simultaneous events:
  - Done edge coinciding with start falling: done is still issued (completion takes priority over abort at edge N+L); the next state is WAIT_LOW, which exits on the next edge.
  - Reset coinciding with any edge: reset wins.
- Timing vs. initiator: start and operands change on negedge; they are sampled on posedge; done is visible before the following negedge.

Test Plan:
- Reset then add: A=8'hFF, B=8'h01, op=001, start at negedge before edge N -> done=1 only at edge N+1, result=16'h0100, err=0; done=0 at N+2.
- Multiply: A=8'hFF, B=8'hFF, op=100, MUL_LATENCY=3 -> done at edge N+3 only, result=16'hFE01; busy=1 on edges N+1..N+3.
- Logic ops back-to-back, start low one cycle between them: and A=8'hF0,B=8'h3C -> 16'h0030; xor A=8'hA5,B=8'h0F -> 16'h00AA; each gets exactly one done pulse.
- no_op: op=000, start high for one edge -> no done; result keeps the prior value 16'h00AA. Illegal op=101 with A=8'h12 -> done at N+1, result=16'h0000, err=1 for one cycle.
- start held high 5 cycles after the done of add A=1,B=2 -> result=16'h0003, a single done pulse, FSM in WAIT_LOW until start falls; a change of op to xor while held does not trigger a new command.
- reset_n pulsed low at edge N+1 of a mul (A=8'h10, B=8'h10) -> done, result and busy go to 0 immediately; no done for that mul; the next add A=2,B=3 returns 16'h0005 at N'+1.
